hit_judge: RTL and testbench

HIT_JUDGE -- requirements
Module: hit_judge

---
 rtl/hit_judge_pkg.sv | 39 +++
 rtl/hit_judge_lane.sv | 66 ++++++
 rtl/hit_judge.sv | 159 +++++++++++++++
 tb/tb_hit_judge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hit_judge_pkg.sv
// Shared definitions for the hit judge: judge codes, FSM states, window bit positions.
package hit_judge_pkg;

    localparam int unsigned NOTE_W      = 27;
    localparam int unsigned WIN_OLD     = 26;
    localparam int unsigned WIN_PERFECT = 25;
    localparam int unsigned WIN_NEW     = 24;
    localparam int unsigned MASK_W      = WIN_OLD - WIN_NEW + 1;
    localparam int unsigned SCORE_W     = 16;
    localparam int unsigned COMBO_W     = 8;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'b00,
        JUDGE_PERFECT = 2'b01,
        JUDGE_GOOD    = 2'b10,
        JUDGE_MISS    = 2'b11
    } judge_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic perfect;
        logic good;
        logic miss;
    } lane_result_t;

    // A miss outranks a hit in the reported code; the hit still scores.
    function automatic judge_t encode_judge(input lane_result_t r);
        if (r.miss)    return JUDGE_MISS;
        if (r.perfect) return JUDGE_PERFECT;
        if (r.good)    return JUDGE_GOOD;
        return JUDGE_NONE;
    endfunction

endpackage

// File: rtl/hit_judge_lane.sv
// One drum lane: key edge detect, consumed-note mask and note claiming.
module lane_judge
    import hit_judge_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              clear,
    input  logic              shift_tick,
    input  logic [MASK_W-1:0] window,
    input  logic              key,
    output lane_result_t      result_c
);

    localparam int unsigned M_OLD  = WIN_OLD - WIN_NEW;
    localparam int unsigned M_PERF = WIN_PERFECT - WIN_NEW;
    localparam int unsigned M_NEW  = 0;

    logic              key_q;
    logic              press;
    logic [MASK_W-1:0] mask_q;
    logic [MASK_W-1:0] mask_n;
    logic [MASK_W-1:0] avail;
    logic [MASK_W-1:0] claim;
    logic [MASK_W-1:0] claimed;

    assign press = key & ~key_q;
    assign avail = window & ~mask_q;

    // Press is resolved on the pre-shift window, then the miss check and shift.
    always_comb begin
        claim    = '0;
        result_c = '0;
        if (play && press) begin
            if (avail[M_PERF]) begin
                claim[M_PERF]    = 1'b1;
                result_c.perfect = 1'b1;
            end else if (avail[M_OLD]) begin
                claim[M_OLD]  = 1'b1;
                result_c.good = 1'b1;
            end else if (avail[M_NEW]) begin
                claim[M_NEW]  = 1'b1;
                result_c.good = 1'b1;
            end
        end
        claimed       = mask_q | claim;
        result_c.miss = play && shift_tick && window[M_OLD] && !claimed[M_OLD];
        mask_n        = mask_q;
        if (clear) begin
            mask_n = '0;
        end else if (play) begin
            mask_n = shift_tick ? {claimed[MASK_W-2:0], 1'b0} : claimed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            key_q  <= key;
            mask_q <= mask_n;
        end
    end

endmodule

// File: rtl/hit_judge.sv
// Three-lane rhythm-game judge: game FSM, per-lane results, score and combo tracking.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int unsigned PERFECT_PTS = 3,
    parameter int unsigned GOOD_PTS    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_tick,
    input  logic [NOTE_W-1:0]  output_red,
    input  logic [NOTE_W-1:0]  output_blue,
    input  logic [NOTE_W-1:0]  output_yellow,
    input  logic               key_red,
    input  logic               key_blue,
    input  logic               key_yellow,
    input  logic               start,
    input  logic               stop,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic [1:0]         judge_red,
    output logic [1:0]         judge_blue,
    output logic [1:0]         judge_yellow,
    output logic               playing
);

    localparam int unsigned PTS_W  = SCORE_W + 2;
    localparam int unsigned CSUM_W = COMBO_W + 1;
    localparam logic [PTS_W-1:0] SCORE_MAX = PTS_W'({SCORE_W{1'b1}});

    state_t state_q;
    state_t state_n;
    logic   play_c;
    logic   clear_c;

    lane_result_t res_red_c;
    lane_result_t res_blue_c;
    lane_result_t res_yellow_c;

    logic [1:0]         n_perfect;
    logic [1:0]         n_good;
    logic [1:0]         n_hits;
    logic               any_miss;
    logic [PTS_W-1:0]   pts;
    logic [PTS_W-1:0]   score_sum;
    logic [CSUM_W-1:0]  combo_sum;
    logic [SCORE_W-1:0] score_n;
    logic [COMBO_W-1:0] combo_n;
    logic [COMBO_W-1:0] max_n;
    logic               unused_low_bits;

    assign unused_low_bits = ^{output_red[WIN_NEW-1:0], output_blue[WIN_NEW-1:0],
                               output_yellow[WIN_NEW-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Start re-arms from IDLE or DONE and clears the game; ignored while playing.
    always_comb begin
        state_n = state_q;
        clear_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_PLAY;
                    clear_c = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign play_c = (state_q == ST_PLAY);

    lane_judge u_lane_red (
        .clk        (clk),
        .reset      (reset),
        .play       (play_c),
        .clear      (clear_c),
        .shift_tick (shift_tick),
        .window     (output_red[WIN_OLD:WIN_NEW]),
        .key        (key_red),
        .result_c   (res_red_c)
    );

    lane_judge u_lane_blue (
        .clk        (clk),
        .reset      (reset),
        .play       (play_c),
        .clear      (clear_c),
        .shift_tick (shift_tick),
        .window     (output_blue[WIN_OLD:WIN_NEW]),
        .key        (key_blue),
        .result_c   (res_blue_c)
    );

    lane_judge u_lane_yellow (
        .clk        (clk),
        .reset      (reset),
        .play       (play_c),
        .clear      (clear_c),
        .shift_tick (shift_tick),
        .window     (output_yellow[WIN_OLD:WIN_NEW]),
        .key        (key_yellow),
        .result_c   (res_yellow_c)
    );

    // Per-cycle point sum and combo arithmetic, both saturating.
    always_comb begin
        n_perfect = 2'(res_red_c.perfect) + 2'(res_blue_c.perfect) + 2'(res_yellow_c.perfect);
        n_good    = 2'(res_red_c.good) + 2'(res_blue_c.good) + 2'(res_yellow_c.good);
        n_hits    = n_perfect + n_good;
        any_miss  = res_red_c.miss | res_blue_c.miss | res_yellow_c.miss;
        pts       = PTS_W'(n_perfect) * PTS_W'(PERFECT_PTS) + PTS_W'(n_good) * PTS_W'(GOOD_PTS);
        score_sum = PTS_W'(score) + pts;
        score_n   = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
        combo_sum = (any_miss ? '0 : CSUM_W'(combo)) + CSUM_W'(n_hits);
        combo_n   = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
        max_n     = (combo_n > max_combo) ? combo_n : max_combo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score        <= '0;
            combo        <= '0;
            max_combo    <= '0;
            judge_red    <= JUDGE_NONE;
            judge_blue   <= JUDGE_NONE;
            judge_yellow <= JUDGE_NONE;
            playing      <= 1'b0;
        end else begin
            playing      <= (state_n == ST_PLAY);
            judge_red    <= play_c ? encode_judge(res_red_c) : JUDGE_NONE;
            judge_blue   <= play_c ? encode_judge(res_blue_c) : JUDGE_NONE;
            judge_yellow <= play_c ? encode_judge(res_yellow_c) : JUDGE_NONE;
            if (clear_c) begin
                score     <= '0;
                combo     <= '0;
                max_combo <= '0;
            end else if (play_c) begin
                score     <= score_n;
                combo     <= combo_n;
                max_combo <= max_n;
            end
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// Directed scoreboard bench for hit_judge.
module tb_hit_judge;
    import hit_judge_pkg::*;

    localparam logic [1:0] JN = JUDGE_NONE;
    localparam logic [1:0] JP = JUDGE_PERFECT;
    localparam logic [1:0] JG = JUDGE_GOOD;
    localparam logic [1:0] JM = JUDGE_MISS;

    logic        clk = 1'b0;
    logic        reset;
    logic        shift_tick;
    logic [26:0] output_red;
    logic [26:0] output_blue;
    logic [26:0] output_yellow;
    logic        key_red;
    logic        key_blue;
    logic        key_yellow;
    logic        start;
    logic        stop;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [1:0]  judge_red;
    logic [1:0]  judge_blue;
    logic [1:0]  judge_yellow;
    logic        playing;

    typedef struct packed {
        logic [1:0]  jr;
        logic [1:0]  jb;
        logic [1:0]  jy;
        logic [15:0] sc;
        logic [7:0]  co;
        logic [7:0]  mc;
        logic        pl;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    hit_judge #(.PERFECT_PTS(3), .GOOD_PTS(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .shift_tick    (shift_tick),
        .output_red    (output_red),
        .output_blue   (output_blue),
        .output_yellow (output_yellow),
        .key_red       (key_red),
        .key_blue      (key_blue),
        .key_yellow    (key_yellow),
        .start         (start),
        .stop          (stop),
        .score         (score),
        .combo         (combo),
        .max_combo     (max_combo),
        .judge_red     (judge_red),
        .judge_blue    (judge_blue),
        .judge_yellow  (judge_yellow),
        .playing       (playing)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string t, input string f, input logic [15:0] obs, input logic [15:0] e);
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s %s observed=%0d expected=%0d", t, f, obs, e);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] jr, input logic [1:0] jb,
                              input logic [1:0] jy, input logic [15:0] sc, input logic [7:0] co,
                              input logic [7:0] mc, input logic pl);
        exp_q.push_back('{jr, jb, jy, sc, co, mc, pl});
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            cmp(t, "judge_red",    16'(judge_red),    16'(e.jr));
            cmp(t, "judge_blue",   16'(judge_blue),   16'(e.jb));
            cmp(t, "judge_yellow", 16'(judge_yellow), 16'(e.jy));
            cmp(t, "score",        score,             e.sc);
            cmp(t, "combo",        16'(combo),        16'(e.co));
            cmp(t, "max_combo",    16'(max_combo),    16'(e.mc));
            cmp(t, "playing",      16'(playing),      16'(e.pl));
        end
    endtask

    // Drive one clock; upstream note registers shift on the same edge as shift_tick.
    task automatic cyc(input logic t, input logic kr, input logic kb, input logic ky,
                       input logic st, input logic sp);
        shift_tick = t;
        key_red    = kr;
        key_blue   = kb;
        key_yellow = ky;
        start      = st;
        stop       = sp;
        @(posedge clk);
        #1;
        shift_tick = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        if (t) begin
            output_red    = output_red << 1;
            output_blue   = output_blue << 1;
            output_yellow = output_yellow << 1;
        end
    endtask

    task automatic step(input string tag, input logic t, input logic kr, input logic kb,
                        input logic ky, input logic st, input logic sp,
                        input logic [1:0] jr, input logic [1:0] jb, input logic [1:0] jy,
                        input logic [15:0] sc, input logic [7:0] co, input logic [7:0] mc,
                        input logic pl);
        expect_out(tag, jr, jb, jy, sc, co, mc, pl);
        cyc(t, kr, kb, ky, st, sp);
        check_out();
    endtask

    // kind: 0 no note, 1 note at bit 25 (perfect), 2 note at bit 24 (good).
    task automatic hit_round(input int kr, input int kb, input int ky);
        if (kr == 1) output_red[25] = 1'b1;    else if (kr == 2) output_red[24] = 1'b1;
        if (kb == 1) output_blue[25] = 1'b1;   else if (kb == 2) output_blue[24] = 1'b1;
        if (ky == 1) output_yellow[25] = 1'b1; else if (ky == 2) output_yellow[24] = 1'b1;
        cyc(1'b0, kr != 0, kb != 0, ky != 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_windows();
        output_red    = '0;
        output_blue   = '0;
        output_yellow = '0;
    endtask

    initial begin
        reset = 1'b1;
        shift_tick = 1'b0; key_red = 1'b0; key_blue = 1'b0; key_yellow = 1'b0;
        start = 1'b0; stop = 1'b0;
        clear_windows();
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", JN, JN, JN, 16'd0, 8'd0, 8'd0, 1'b0);
        check_out();
        reset = 1'b0;

        step("start",          0,0,0,0,1,0, JN,JN,JN, 16'd0,  8'd0, 8'd0, 1'b1);
        output_red[25] = 1'b1;
        step("red_perfect",    0,1,0,0,0,0, JP,JN,JN, 16'd3,  8'd1, 8'd1, 1'b1);
        step("held_key",       0,1,0,0,0,0, JN,JN,JN, 16'd3,  8'd1, 8'd1, 1'b1);
        step("tick_consumed",  1,0,0,0,0,0, JN,JN,JN, 16'd3,  8'd1, 8'd1, 1'b1);
        step("tick_out",       1,0,0,0,0,0, JN,JN,JN, 16'd3,  8'd1, 8'd1, 1'b1);

        output_red[25] = 1'b1; output_blue[25] = 1'b1; output_yellow[25] = 1'b1;
        step("triple_perfect", 0,1,1,1,0,0, JP,JP,JP, 16'd12, 8'd4, 8'd4, 1'b1);
        step("release_all",    0,0,0,0,0,0, JN,JN,JN, 16'd12, 8'd4, 8'd4, 1'b1);
        step("press_consumed", 0,1,0,0,0,0, JN,JN,JN, 16'd12, 8'd4, 8'd4, 1'b1);
        step("tick_no_miss_a", 1,0,0,0,0,0, JN,JN,JN, 16'd12, 8'd4, 8'd4, 1'b1);
        step("tick_no_miss_b", 1,0,0,0,0,0, JN,JN,JN, 16'd12, 8'd4, 8'd4, 1'b1);

        output_yellow[26] = 1'b1;
        step("press_on_tick",  1,0,0,1,0,0, JN,JN,JG, 16'd13, 8'd5, 8'd5, 1'b1);
        step("press_empty",    0,0,1,0,0,0, JN,JN,JN, 16'd13, 8'd5, 8'd5, 1'b1);
        output_blue[26] = 1'b1;
        step("blue_miss",      1,0,0,0,0,0, JN,JM,JN, 16'd13, 8'd0, 8'd5, 1'b1);
        output_red[26] = 1'b1; output_red[25] = 1'b1;
        step("hit_and_miss",   1,1,0,0,0,0, JM,JN,JN, 16'd16, 8'd1, 8'd5, 1'b1);
        step("claimed_out",    1,0,0,0,0,0, JN,JN,JN, 16'd16, 8'd1, 8'd5, 1'b1);
        step("stop",           0,0,0,0,0,1, JN,JN,JN, 16'd16, 8'd1, 8'd5, 1'b0);
        output_red[25] = 1'b1;
        step("done_ignored",   0,1,0,0,0,0, JN,JN,JN, 16'd16, 8'd1, 8'd5, 1'b0);

        clear_windows();
        step("restart",        0,0,0,0,1,0, JN,JN,JN, 16'd0,  8'd0, 8'd0, 1'b1);
        output_yellow[26] = 1'b1; output_yellow[25] = 1'b1;
        step("yellow_first",   0,0,0,1,0,0, JN,JN,JP, 16'd3,  8'd1, 8'd1, 1'b1);
        step("yellow_release", 0,0,0,0,0,0, JN,JN,JN, 16'd3,  8'd1, 8'd1, 1'b1);
        step("yellow_second",  0,0,0,1,0,0, JN,JN,JG, 16'd4,  8'd2, 8'd2, 1'b1);
        step("yellow_tick_a",  1,0,0,0,0,0, JN,JN,JN, 16'd4,  8'd2, 8'd2, 1'b1);
        step("yellow_tick_b",  1,0,0,0,0,0, JN,JN,JN, 16'd4,  8'd2, 8'd2, 1'b1);

        step("stop_2",         0,0,0,0,0,1, JN,JN,JN, 16'd4,  8'd2, 8'd2, 1'b0);
        step("start_3",        0,0,0,0,1,0, JN,JN,JN, 16'd0,  8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 7281; i++) hit_round(1, 1, 1);
        hit_round(1, 2, 2);
        step("pre_saturate",   1,0,0,0,0,0, JN,JN,JN, 16'd65534, 8'd255, 8'd255, 1'b1);
        output_red[25] = 1'b1; output_blue[25] = 1'b1; output_yellow[25] = 1'b1;
        step("saturate",       0,1,1,1,0,0, JP,JP,JP, 16'd65535, 8'd255, 8'd255, 1'b1);
        step("saturate_hold",  1,0,0,0,0,0, JN,JN,JN, 16'd65535, 8'd255, 8'd255, 1'b1);

        step("stop_3",         0,0,0,0,0,1, JN,JN,JN, 16'd65535, 8'd255, 8'd255, 1'b0);
        clear_windows();
        step("start_4",        0,0,0,0,1,0, JN,JN,JN, 16'd0,  8'd0,  8'd0,  1'b1);
        for (int i = 0; i < 4; i++) hit_round(1, 1, 1);
        hit_round(1, 1, 0);
        step("score_42",       0,0,0,0,0,0, JN,JN,JN, 16'd42, 8'd14, 8'd14, 1'b1);

        #3;
        reset = 1'b1;
        #1;
        expect_out("async_reset", JN, JN, JN, 16'd0, 8'd0, 8'd0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_windows();
        output_red[25] = 1'b1;
        step("idle_press",     0,1,0,0,0,0, JN,JN,JN, 16'd0, 8'd0, 8'd0, 1'b0);
        step("start_5",        0,0,0,0,1,0, JN,JN,JN, 16'd0, 8'd0, 8'd0, 1'b1);
        step("post_reset_hit", 0,1,0,0,0,0, JP,JN,JN, 16'd3, 8'd1, 8'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
